// File: rtl/joy_pkg.sv
// joy_pkg: shared types and constants for the joystick shift-chain sequencer.
//   joy_state_t  - sequencer states
//   P1_*/P2_*    - chain bit index (k) of each button
//   RIGHT..FIRE2 - bit position of each button in a joystick word
//   map_player() - builds one active-low joystick word from six chain bits
package joy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    COMPARE
  } joy_state_t;

  // Chain order for each player: fire2, fire1, right, left, down, up
  localparam int P1_FIRE2 = 2;
  localparam int P1_FIRE1 = 3;
  localparam int P1_RIGHT = 4;
  localparam int P1_LEFT  = 5;
  localparam int P1_DOWN  = 6;
  localparam int P1_UP    = 7;
  localparam int P2_FIRE2 = 8;
  localparam int P2_FIRE1 = 9;
  localparam int P2_RIGHT = 10;
  localparam int P2_LEFT  = 11;
  localparam int P2_DOWN  = 12;
  localparam int P2_UP    = 13;

  localparam int RIGHT = 0;
  localparam int LEFT  = 1;
  localparam int DOWN  = 2;
  localparam int UP    = 3;
  localparam int FIRE1 = 4;
  localparam int FIRE2 = 5;

  // i_f holds six consecutive chain bits, i_f[0] being the fire2 position.
  // Bits 7:6 of the result stay 1.
  function automatic logic [7:0] map_player(input logic [5:0] i_f);
    logic [7:0] w_word;
    w_word        = 8'hFF;
    w_word[FIRE2] = i_f[0];
    w_word[FIRE1] = i_f[1];
    w_word[RIGHT] = i_f[2];
    w_word[LEFT]  = i_f[3];
    w_word[DOWN]  = i_f[4];
    w_word[UP]    = i_f[5];
    return w_word;
  endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// joy_tick_gen: free-running divider producing a one-clk enable every
// CLK_DIV cycles. Cleared only by reset.
//   i_clk   - system clock
//   i_reset - synchronous active-high reset
//   o_tick  - high for one clk when the counter wraps
module joy_tick_gen #(
  parameter int CLK_DIV = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int              CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset)            r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/joy_scan_ctrl.sv
// joy_scan_ctrl: sequencer for the joystick parallel-in/serial-out chain.
// Loads the chain, shifts NBITS bits out on JOY_CLK, and publishes the two
// joystick words once SETTLE_FRAMES consecutive identical frames are seen.
//   clk, reset  - system clock, synchronous active-high reset
//   scan_en     - frames run back-to-back while high
//   JOY_DATA    - serial chain data (active-low buttons)
//   JOY_CLK     - registered shift clock to the chain
//   JOY_LOAD    - registered parallel-load strobe, active-low
//   JOY_SELECT  - adaptor select, tied high
//   joystick1/2 - {1,1,fire2,fire1,up,down,left,right}, active-low
//   frame_valid - one-clk pulse when joystick1/2 update
//   busy        - sequencer not idle
module joy_scan_ctrl
  import joy_pkg::*;
#(
  parameter int CLK_DIV       = 64,
  parameter int NBITS         = 16,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic       JOY_DATA,
  output logic       JOY_CLK,
  output logic       JOY_LOAD,
  output logic       JOY_SELECT,
  output logic [7:0] joystick1,
  output logic [7:0] joystick2,
  output logic       frame_valid,
  output logic       busy
);

  localparam int            KW    = $clog2(NBITS);
  localparam int            MW    = $clog2(SETTLE_FRAMES + 1);
  localparam logic [KW-1:0] KLAST = KW'(NBITS - 1);
  localparam logic [MW-1:0] MLAST = MW'(SETTLE_FRAMES);

  joy_state_t       r_state, w_nstate;
  logic             w_tick;
  logic             w_busy;
  logic             r_lcnt;      // ticks already spent in LOAD (0 or 1)
  logic [KW-1:0]    r_k;
  logic [NBITS-1:0] r_sample;
  logic [NBITS-1:0] r_prev;
  logic [MW-1:0]    r_match;
  logic [MW-1:0]    w_match_nx;
  logic             r_jclk;
  logic             r_jload;
  logic [7:0]       r_j1, r_j2;
  logic             r_fv;

  joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk   (clk),
    .i_reset (reset),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_nstate = r_state;
    w_busy   = (r_state != IDLE);
    case (r_state)
      IDLE:     if (w_tick && scan_en) w_nstate = LOAD;
      LOAD:     if (w_tick && r_lcnt)  w_nstate = SHIFT_LO;
      SHIFT_LO: if (w_tick)            w_nstate = SHIFT_HI;
      SHIFT_HI: if (w_tick)            w_nstate = (r_k == KLAST) ? COMPARE : SHIFT_LO;
      COMPARE:                         w_nstate = IDLE;
      default:                         w_nstate = IDLE;
    endcase
  end

  // Saturating run length of identical frames; a changed frame restarts at 1.
  always_comb begin
    w_match_nx = MW'(1);
    if (r_sample == r_prev)
      w_match_nx = (r_match == MLAST) ? MLAST : r_match + MW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_lcnt   <= 1'b0;
      r_k      <= '0;
      r_sample <= '1;
      r_prev   <= '1;
      r_match  <= '0;
      r_jclk   <= 1'b0;
      r_jload  <= 1'b1;
      r_j1     <= 8'hFF;
      r_j2     <= 8'hFF;
      r_fv     <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_fv    <= 1'b0;
      case (r_state)
        IDLE: if (w_nstate == LOAD) begin
          r_jload <= 1'b0;
          r_lcnt  <= 1'b0;
        end
        LOAD: if (w_tick) begin
          if (r_lcnt) begin
            r_jload <= 1'b1;
            r_k     <= '0;
          end else begin
            r_lcnt <= 1'b1;
          end
        end
        SHIFT_LO: if (w_tick) begin
          // JOY_DATA is still the pre-edge bit: the chain shifts on our rise
          r_jclk        <= 1'b1;
          r_sample[r_k] <= JOY_DATA;
        end
        SHIFT_HI: if (w_tick) begin
          r_jclk <= 1'b0;
          r_k    <= r_k + KW'(1);
        end
        COMPARE: begin
          r_match <= w_match_nx;
          r_prev  <= r_sample;
          if (w_match_nx == MLAST) begin
            r_j1 <= map_player(r_sample[P1_UP:P1_FIRE2]);
            r_j2 <= map_player(r_sample[P2_UP:P2_FIRE2]);
            r_fv <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign JOY_CLK     = r_jclk;
  assign JOY_LOAD    = r_jload;
  assign JOY_SELECT  = 1'b1;
  assign joystick1   = r_j1;
  assign joystick2   = r_j2;
  assign frame_valid = r_fv;
  assign busy        = w_busy;

endmodule
